bias_startup_seq: RTL and testbench

- Synchronous controller for one EG1D80V bias/bandgap macro: sequences enable, bandgap startup pulse and settle wait.
- Stages the three trim words; brings up N_CH current-bias channels in a staggered ramp.
- Supervises the macro's asynchronous BG_VALID_N flag and traps faults.
- Sits in the always-on digital domain between the power-management registers and the bias macro pins.

---
 rtl/bias_seq_pkg.sv | 34 +++
 rtl/bias_sync2.sv | 24 ++
 rtl/bias_startup_seq.sv | 196 +++++++++++++++++++
 tb/tb_bias_startup_seq.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_seq_pkg.sv
// Shared types and constants for the bias/bandgap startup sequencer.
package bias_seq_pkg;

    // Trim word widths of the bias macro.
    localparam int TRIM_BIAS_W = 4;
    localparam int TRIM_CURV_W = 5;
    localparam int TRIM_VBG_W  = 5;

    // Trim values applied out of reset and whenever no trim has been written.
    localparam logic [TRIM_BIAS_W-1:0] TRIM_BIAS_RST = 4'h8;
    localparam logic [TRIM_CURV_W-1:0] TRIM_CURV_RST = 5'h10;
    localparam logic [TRIM_VBG_W-1:0]  TRIM_VBG_RST  = 5'h10;

    // Sequencer states; the encoding is visible on the debug state output.
    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_STARTUP = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_RAMP    = 3'd3,
        ST_READY   = 3'd4,
        ST_FAULT   = 3'd5
    } seqState_t;

    // Largest of four cycle counts, used to size the shared down-counter.
    function automatic int maxOf4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/bias_sync2.sv
// Two-flop synchroniser for a single asynchronous level with a selectable reset value.
module bias_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; both start at the reset value so q never glitches out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bias_startup_seq.sv
// Startup sequencer for one bias/bandgap macro: enable, startup pulse, settle,
// staggered channel ramp, valid-flag supervision and fault trapping.
module bias_startup_seq
    import bias_seq_pkg::*;
#(
    parameter int N_CH           = 16,
    parameter int STARTUP_CYCLES = 16,
    parameter int SETTLE_CYCLES  = 256,
    parameter int STAGGER_CYCLES = 4,
    parameter int GLITCH_CYCLES  = 3
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic                   EN_REQ_I,
    input  logic                   VBIAS_REQ_I,
    input  logic [N_CH-1:0]        CH_EN_I,
    input  logic                   TRIM_WE_I,
    input  logic [TRIM_BIAS_W-1:0] TRIM_BIAS_D_I,
    input  logic [TRIM_CURV_W-1:0] TRIM_CURV_D_I,
    input  logic [TRIM_VBG_W-1:0]  TRIM_VBG_D_I,
    input  logic                   BG_VALID_N_I,
    output logic                   EN_O,
    output logic                   BG_STARTUP_O,
    output logic                   EN_VBIAS_O,
    output logic [TRIM_BIAS_W-1:0] TRIM_BIAS_O,
    output logic [TRIM_CURV_W-1:0] TRIM_CURV_O,
    output logic [TRIM_VBG_W-1:0]  TRIM_VBG_O,
    output logic [N_CH-1:0]        CH_EN_O,
    output logic                   READY_O,
    output logic                   FAULT_O,
    output logic [2:0]             STATE_O
);

    localparam int CNT_MAX = maxOf4(STARTUP_CYCLES, SETTLE_CYCLES, STAGGER_CYCLES, GLITCH_CYCLES);
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CW-1:0]   STARTUP_LOAD = CW'(STARTUP_CYCLES - 1);
    localparam logic [CW-1:0]   SETTLE_LOAD  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]   STAGGER_LOAD = CW'(STAGGER_CYCLES - 1);
    localparam logic [CW-1:0]   GLITCH_LOAD  = CW'(GLITCH_CYCLES - 1);
    localparam logic [IW-1:0]   LAST_IDX     = IW'(N_CH - 1);
    localparam logic [N_CH-1:0] CH_ONE       = N_CH'(1);

    seqState_t               state;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           chIdx;
    logic [IW-1:0]           nextIdx;
    logic [N_CH-1:0]         nextChBit;
    logic                    vnS;
    logic [TRIM_BIAS_W-1:0]  shadowBias;
    logic [TRIM_CURV_W-1:0]  shadowCurv;
    logic [TRIM_VBG_W-1:0]   shadowVbg;
    logic [TRIM_BIAS_W-1:0]  loadBias;
    logic [TRIM_CURV_W-1:0]  loadCurv;
    logic [TRIM_VBG_W-1:0]   loadVbg;

    bias_sync2 #(.RST_VAL(1'b1)) uValidSync (
        .clk (CLK_I),
        .rst (RST_I),
        .d   (BG_VALID_N_I),
        .q   (vnS)
    );

    // A trim strobe coinciding with power-up writes straight through to the macro.
    assign loadBias  = TRIM_WE_I ? TRIM_BIAS_D_I : shadowBias;
    assign loadCurv  = TRIM_WE_I ? TRIM_CURV_D_I : shadowCurv;
    assign loadVbg   = TRIM_WE_I ? TRIM_VBG_D_I  : shadowVbg;
    assign nextIdx   = chIdx + 1'b1;
    assign nextChBit = CH_ONE << nextIdx;
    assign STATE_O   = state;

    // Shadow trims capture every strobe regardless of state.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            shadowBias <= TRIM_BIAS_RST;
            shadowCurv <= TRIM_CURV_RST;
            shadowVbg  <= TRIM_VBG_RST;
        end else if (TRIM_WE_I) begin
            shadowBias <= TRIM_BIAS_D_I;
            shadowCurv <= TRIM_CURV_D_I;
            shadowVbg  <= TRIM_VBG_D_I;
        end
    end

    // Sequencer FSM with registered macro outputs; dropping the request always wins.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state        <= ST_OFF;
            cnt          <= '0;
            chIdx        <= '0;
            EN_O         <= 1'b0;
            BG_STARTUP_O <= 1'b0;
            EN_VBIAS_O   <= 1'b0;
            CH_EN_O      <= '0;
            READY_O      <= 1'b0;
            FAULT_O      <= 1'b0;
            TRIM_BIAS_O  <= TRIM_BIAS_RST;
            TRIM_CURV_O  <= TRIM_CURV_RST;
            TRIM_VBG_O   <= TRIM_VBG_RST;
        end else if (!EN_REQ_I) begin
            state        <= ST_OFF;
            cnt          <= '0;
            chIdx        <= '0;
            EN_O         <= 1'b0;
            BG_STARTUP_O <= 1'b0;
            EN_VBIAS_O   <= 1'b0;
            CH_EN_O      <= '0;
            READY_O      <= 1'b0;
            FAULT_O      <= 1'b0;
        end else begin
            unique case (state)
                ST_OFF: begin
                    state        <= ST_STARTUP;
                    cnt          <= STARTUP_LOAD;
                    EN_O         <= 1'b1;
                    BG_STARTUP_O <= 1'b1;
                    TRIM_BIAS_O  <= loadBias;
                    TRIM_CURV_O  <= loadCurv;
                    TRIM_VBG_O   <= loadVbg;
                end
                ST_STARTUP: begin
                    if (cnt == '0) begin
                        state        <= ST_SETTLE;
                        cnt          <= SETTLE_LOAD;
                        BG_STARTUP_O <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (vnS) begin
                        state      <= ST_FAULT;
                        EN_O       <= 1'b0;
                        EN_VBIAS_O <= 1'b0;
                        CH_EN_O    <= '0;
                        FAULT_O    <= 1'b1;
                    end else begin
                        // Slot 0 opens on the entry edge; channels held across a re-settle stay on.
                        state      <= ST_RAMP;
                        cnt        <= STAGGER_LOAD;
                        chIdx      <= '0;
                        CH_EN_O    <= CH_EN_O | (CH_EN_I & CH_ONE);
                        EN_VBIAS_O <= VBIAS_REQ_I;
                    end
                end
                ST_RAMP: begin
                    EN_VBIAS_O <= VBIAS_REQ_I;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (chIdx == LAST_IDX) begin
                        state   <= ST_READY;
                        cnt     <= GLITCH_LOAD;
                        READY_O <= 1'b1;
                    end else begin
                        // Masked channels still use up their stagger slot.
                        chIdx   <= nextIdx;
                        cnt     <= STAGGER_LOAD;
                        CH_EN_O <= CH_EN_O | (CH_EN_I & nextChBit);
                    end
                end
                ST_READY: begin
                    if (vnS && cnt == '0) begin
                        state      <= ST_FAULT;
                        EN_O       <= 1'b0;
                        EN_VBIAS_O <= 1'b0;
                        CH_EN_O    <= '0;
                        READY_O    <= 1'b0;
                        FAULT_O    <= 1'b1;
                    end else if (TRIM_WE_I) begin
                        // New trim goes straight to the macro, then the bandgap re-settles with loads held.
                        state       <= ST_SETTLE;
                        cnt         <= SETTLE_LOAD;
                        READY_O     <= 1'b0;
                        TRIM_BIAS_O <= TRIM_BIAS_D_I;
                        TRIM_CURV_O <= TRIM_CURV_D_I;
                        TRIM_VBG_O  <= TRIM_VBG_D_I;
                    end else begin
                        CH_EN_O    <= CH_EN_I;
                        EN_VBIAS_O <= VBIAS_REQ_I;
                        cnt        <= vnS ? (cnt - 1'b1) : GLITCH_LOAD;
                    end
                end
                ST_FAULT: begin
                    FAULT_O <= 1'b1;
                end
                default: begin
                    state <= ST_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bias_startup_seq.sv
// Self-checking bench for bias_startup_seq: checkpoint table, directed corner sequences,
// and randomized bring-ups scored against a timeline model.
module tb_bias_startup_seq;

    localparam int N_CH       = 16;
    localparam int STARTUP_C  = 16;
    localparam int SETTLE_C   = 256;
    localparam int STAGGER_C  = 4;
    localparam int GLITCH_C   = 3;
    localparam int OBS_W      = 8 + N_CH;
    localparam int RAMP_START = STARTUP_C + SETTLE_C + 1;
    localparam int READY_AT   = RAMP_START + N_CH * STAGGER_C;
    localparam int NVEC       = 16;

    logic            CLK_I = 1'b0;
    logic            RST_I = 1'b1;
    logic            EN_REQ_I = 1'b0;
    logic            VBIAS_REQ_I = 1'b0;
    logic [N_CH-1:0] CH_EN_I = '0;
    logic            TRIM_WE_I = 1'b0;
    logic [3:0]      TRIM_BIAS_D_I = '0;
    logic [4:0]      TRIM_CURV_D_I = '0;
    logic [4:0]      TRIM_VBG_D_I = '0;
    logic            BG_VALID_N_I = 1'b0;
    logic            EN_O, BG_STARTUP_O, EN_VBIAS_O, READY_O, FAULT_O;
    logic [3:0]      TRIM_BIAS_O;
    logic [4:0]      TRIM_CURV_O, TRIM_VBG_O;
    logic [N_CH-1:0] CH_EN_O;
    logic [2:0]      STATE_O;

    int checks = 0;
    int errors = 0;
    logic [OBS_W-1:0] exp_q[$];

    typedef struct {
        logic [15:0] mask;
        int          n;
        logic [2:0]  st;
        logic        bgs;
        logic        rdy;
        logic [15:0] ch;
    } vec_t;
    vec_t vecs[NVEC];

    bias_startup_seq #(
        .N_CH(N_CH), .STARTUP_CYCLES(STARTUP_C), .SETTLE_CYCLES(SETTLE_C),
        .STAGGER_CYCLES(STAGGER_C), .GLITCH_CYCLES(GLITCH_C)
    ) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .EN_REQ_I(EN_REQ_I), .VBIAS_REQ_I(VBIAS_REQ_I),
        .CH_EN_I(CH_EN_I), .TRIM_WE_I(TRIM_WE_I), .TRIM_BIAS_D_I(TRIM_BIAS_D_I),
        .TRIM_CURV_D_I(TRIM_CURV_D_I), .TRIM_VBG_D_I(TRIM_VBG_D_I),
        .BG_VALID_N_I(BG_VALID_N_I), .EN_O(EN_O), .BG_STARTUP_O(BG_STARTUP_O),
        .EN_VBIAS_O(EN_VBIAS_O), .TRIM_BIAS_O(TRIM_BIAS_O), .TRIM_CURV_O(TRIM_CURV_O),
        .TRIM_VBG_O(TRIM_VBG_O), .CH_EN_O(CH_EN_O), .READY_O(READY_O),
        .FAULT_O(FAULT_O), .STATE_O(STATE_O)
    );

    // Clock generation.
    always #5 CLK_I = ~CLK_I;

    // Hard stop in case the sequence never finishes.
    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic stepCycle();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [OBS_W-1:0] obs();
        return {STATE_O, EN_O, BG_STARTUP_O, EN_VBIAS_O, READY_O, FAULT_O, CH_EN_O};
    endfunction

    // Expected observable outputs n edges after the request is first seen, from the
    // bring-up timeline: startup pulse, settle wait, one stagger slot per channel, ready.
    function automatic logic [OBS_W-1:0] modelObs(input int n, input logic [N_CH-1:0] mask,
                                                  input logic vb);
        logic [N_CH-1:0] ch;
        ch = '0;
        if (n <= STARTUP_C) return {3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ch};
        if (n < RAMP_START) return {3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ch};
        if (n < READY_AT) begin
            for (int j = 0; j < N_CH; j++)
                if (n >= RAMP_START + STAGGER_C * j) ch[j] = mask[j];
            return {3'd3, 1'b1, 1'b0, vb, 1'b0, 1'b0, ch};
        end
        return {3'd4, 1'b1, 1'b0, vb, 1'b1, 1'b0, mask};
    endfunction

    task automatic scoreObs(input string name);
        logic [OBS_W-1:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s act=empty_queue exp=entry", name);
        end else begin
            exp = exp_q.pop_front();
            checkVal(name, 32'(obs()), 32'(exp));
        end
    endtask

    task automatic doReset();
        RST_I = 1'b1;
        EN_REQ_I = 1'b0;
        VBIAS_REQ_I = 1'b0;
        CH_EN_I = '0;
        TRIM_WE_I = 1'b0;
        TRIM_BIAS_D_I = '0;
        TRIM_CURV_D_I = '0;
        TRIM_VBG_D_I = '0;
        BG_VALID_N_I = 1'b0;
        stepCycle();
        stepCycle();
        RST_I = 1'b0;
    endtask

    task automatic startBringup(input logic [N_CH-1:0] mask, input logic vb);
        EN_REQ_I = 1'b1;
        CH_EN_I = mask;
        VBIAS_REQ_I = vb;
    endtask

    task automatic stepTo(inout int n, input int target);
        while (n < target) begin
            stepCycle();
            n++;
        end
    endtask

    task automatic writeTrim(input logic [3:0] b, input logic [4:0] c, input logic [4:0] v);
        TRIM_WE_I = 1'b1;
        TRIM_BIAS_D_I = b;
        TRIM_CURV_D_I = c;
        TRIM_VBG_D_I = v;
    endtask

    task automatic resetCheck();
        doReset();
        RST_I = 1'b1;
        stepCycle();
        checkVal("reset_obs", 32'(obs()), 32'h0);
        checkVal("reset_trims", {18'h0, TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O},
                 {18'h0, 4'h8, 5'h10, 5'h10});
        RST_I = 1'b0;
        repeat (3) stepCycle();
        checkVal("idle_off", 32'(obs()), 32'h0);
    endtask

    task automatic runVectors();
        int n;
        n = 0;
        for (int i = 0; i < NVEC; i++) begin
            if (i == 0 || vecs[i].mask != vecs[i - 1].mask) begin
                doReset();
                startBringup(vecs[i].mask, 1'b1);
                n = 0;
            end
            stepTo(n, vecs[i].n);
            checkVal($sformatf("vec%0d_n%0d", i, vecs[i].n),
                     {11'h0, STATE_O, BG_STARTUP_O, READY_O, CH_EN_O},
                     {11'h0, vecs[i].st, vecs[i].bgs, vecs[i].rdy, vecs[i].ch});
        end
    endtask

    task automatic settleFailTest();
        int n;
        n = 0;
        doReset();
        BG_VALID_N_I = 1'b1;
        startBringup(16'hFFFF, 1'b1);
        stepTo(n, RAMP_START - 1);
        checkVal("sfail_settle", {28'h0, STATE_O, EN_O}, {28'h0, 3'd2, 1'b1});
        stepTo(n, RAMP_START);
        checkVal("sfail_fault", 32'(obs()), 32'({3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0}));
        BG_VALID_N_I = 1'b0;
        repeat (5) stepCycle();
        checkVal("sfail_sticky", {28'h0, STATE_O, FAULT_O}, {28'h0, 3'd5, 1'b1});
        EN_REQ_I = 1'b0;
        stepCycle();
        checkVal("sfail_exit", 32'(obs()), 32'h0);
    endtask

    task automatic glitchTest();
        int n;
        n = 0;
        doReset();
        startBringup(16'hFFFF, 1'b0);
        stepTo(n, READY_AT);
        checkVal("glitch_ready", {29'h0, STATE_O}, {29'h0, 3'd4});
        BG_VALID_N_I = 1'b1;
        repeat (2) stepCycle();
        BG_VALID_N_I = 1'b0;
        repeat (6) stepCycle();
        checkVal("glitch_short", {28'h0, STATE_O, FAULT_O}, {28'h0, 3'd4, 1'b0});
        BG_VALID_N_I = 1'b1;
        repeat (4) stepCycle();
        checkVal("glitch_pre", {28'h0, STATE_O, READY_O}, {28'h0, 3'd4, 1'b1});
        stepCycle();
        checkVal("glitch_fault", 32'(obs()), 32'({3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0}));
        BG_VALID_N_I = 1'b0;
    endtask

    task automatic trimTest();
        int n;
        n = 0;
        doReset();
        writeTrim(4'hA, 5'h01, 5'h02);
        stepCycle();
        TRIM_WE_I = 1'b0;
        checkVal("trim_off_shadow", {18'h0, TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O},
                 {18'h0, 4'h8, 5'h10, 5'h10});
        startBringup(16'hFFFF, 1'b1);
        stepTo(n, 1);
        checkVal("trim_load", {18'h0, TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O},
                 {18'h0, 4'hA, 5'h01, 5'h02});
        stepTo(n, 100);
        writeTrim(4'h5, 5'h05, 5'h05);
        stepTo(n, 101);
        TRIM_WE_I = 1'b0;
        checkVal("trim_settle_hold", {18'h0, TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O},
                 {18'h0, 4'hA, 5'h01, 5'h02});
        stepTo(n, READY_AT);
        writeTrim(4'h3, 5'h07, 5'h1F);
        stepCycle();
        TRIM_WE_I = 1'b0;
        checkVal("trim_ready_write", {18'h0, TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O},
                 {18'h0, 4'h3, 5'h07, 5'h1F});
        checkVal("trim_ready_resettle", {12'h0, STATE_O, READY_O, CH_EN_O},
                 {12'h0, 3'd2, 1'b0, 16'hFFFF});
        repeat (SETTLE_C - 1) stepCycle();
        checkVal("trim_settle_len", {29'h0, STATE_O}, {29'h0, 3'd2});
        stepCycle();
        checkVal("trim_to_ramp", {29'h0, STATE_O}, {29'h0, 3'd3});
        EN_REQ_I = 1'b0;
        stepCycle();
        EN_REQ_I = 1'b1;
        stepCycle();
        checkVal("trim_shadow_reload", {18'h0, TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O},
                 {18'h0, 4'h3, 5'h07, 5'h1F});
    endtask

    task automatic abortTest();
        int n;
        n = 0;
        doReset();
        startBringup(16'hFFFF, 1'b1);
        stepTo(n, RAMP_START + 5 * STAGGER_C);
        checkVal("abort_ch5", 32'(CH_EN_O), 32'h003F);
        EN_REQ_I = 1'b0;
        stepCycle();
        checkVal("abort_off", 32'(obs()), 32'h0);
        n = 0;
        startBringup(16'hFFFF, 1'b1);
        writeTrim(4'h1, 5'h02, 5'h03);
        stepTo(n, 1);
        TRIM_WE_I = 1'b0;
        checkVal("abort_writethru", {18'h0, TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O},
                 {18'h0, 4'h1, 5'h02, 5'h03});
        stepTo(n, 5);
        checkVal("abort_startup", {28'h0, STATE_O, BG_STARTUP_O}, {28'h0, 3'd1, 1'b1});
        #2;
        RST_I = 1'b1;
        #1;
        checkVal("async_rst_obs", 32'(obs()), 32'h0);
        checkVal("async_rst_trims", {18'h0, TRIM_BIAS_O, TRIM_CURV_O, TRIM_VBG_O},
                 {18'h0, 4'h8, 5'h10, 5'h10});
        stepCycle();
        RST_I = 1'b0;
        EN_REQ_I = 1'b0;
    endtask

    task automatic randomRun();
        logic [N_CH-1:0] mask;
        logic vb;
        doReset();
        mask = N_CH'($urandom);
        vb = 1'($urandom_range(0, 1));
        startBringup(mask, vb);
        for (int n = 1; n <= READY_AT + 30; n++) begin
            stepCycle();
            exp_q.push_back(modelObs(n, mask, vb));
            scoreObs($sformatf("rand_n%0d", n));
            vb = 1'($urandom_range(0, 1));
            VBIAS_REQ_I = vb;
            if (n >= READY_AT) begin
                mask = N_CH'($urandom);
                CH_EN_I = mask;
            end
        end
    endtask

    initial begin
        vecs[0]  = '{16'hFFFF, 1,   3'd1, 1'b1, 1'b0, 16'h0000};
        vecs[1]  = '{16'hFFFF, 16,  3'd1, 1'b1, 1'b0, 16'h0000};
        vecs[2]  = '{16'hFFFF, 17,  3'd2, 1'b0, 1'b0, 16'h0000};
        vecs[3]  = '{16'hFFFF, 272, 3'd2, 1'b0, 1'b0, 16'h0000};
        vecs[4]  = '{16'hFFFF, 273, 3'd3, 1'b0, 1'b0, 16'h0001};
        vecs[5]  = '{16'hFFFF, 276, 3'd3, 1'b0, 1'b0, 16'h0001};
        vecs[6]  = '{16'hFFFF, 277, 3'd3, 1'b0, 1'b0, 16'h0003};
        vecs[7]  = '{16'hFFFF, 332, 3'd3, 1'b0, 1'b0, 16'h7FFF};
        vecs[8]  = '{16'hFFFF, 333, 3'd3, 1'b0, 1'b0, 16'hFFFF};
        vecs[9]  = '{16'hFFFF, 336, 3'd3, 1'b0, 1'b0, 16'hFFFF};
        vecs[10] = '{16'hFFFF, 337, 3'd4, 1'b0, 1'b1, 16'hFFFF};
        vecs[11] = '{16'h0005, 273, 3'd3, 1'b0, 1'b0, 16'h0001};
        vecs[12] = '{16'h0005, 280, 3'd3, 1'b0, 1'b0, 16'h0001};
        vecs[13] = '{16'h0005, 281, 3'd3, 1'b0, 1'b0, 16'h0005};
        vecs[14] = '{16'h0005, 336, 3'd3, 1'b0, 1'b0, 16'h0005};
        vecs[15] = '{16'h0005, 337, 3'd4, 1'b0, 1'b1, 16'h0005};

        resetCheck();
        runVectors();
        settleFailTest();
        glitchTest();
        trimTest();
        abortTest();
        for (int r = 0; r < 3; r++) randomRun();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
